// File: rtl/uart_cmd_framer_if.sv
// Byte-in / write-out bundle for uart_cmd_framer.
// valid_in is a one-cycle strobe with no back-pressure; the write side is valid/ready:
// a write transfers on any clk_in edge where wr_valid && wr_ready, and wr_addr/wr_data
// are held stable while wr_valid && !wr_ready.
interface uart_cmd_framer_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  valid_in;
    logic [7:0]            data_in;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;

    // master: the framer (consumes UART bytes, issues writes)
    modport master (
        input  valid_in, data_in, wr_ready,
        output wr_valid, wr_addr, wr_data
    );

    // slave: the UART receiver plus the write sink
    modport slave (
        output valid_in, data_in, wr_ready,
        input  wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/uart_cmd_framer.sv
// Frames SYNC/ADDR/LEN/payload/CHK byte streams into write bursts with error pulses.
// Optional ack channel enabled by defining UART_CMD_FRAMER_ACK_EN.
module uart_cmd_framer #(
    parameter int         MAX_LEN        = 16,
    parameter int         ADDR_WIDTH     = 8,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    uart_cmd_framer_if.master  bus,
    output logic               frame_ok,
    output logic               err_checksum,
    output logic               err_len,
    output logic               err_timeout,
    output logic [7:0]         drop_count,
    output logic               busy_out,
    output logic [2:0]         state_dbg
`ifdef UART_CMD_FRAMER_ACK_EN
    ,
    output logic               ack_valid,
    output logic [7:0]         ack_data,
    input  logic               ack_ready
`endif
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_ADDR    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_EMIT    = 3'd5
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [IW-1:0]         last_idx;
    logic [IW-1:0]         idx;
    logic [7:0]            chk;
    logic [TW-1:0]         tmo_cnt;
    logic [7:0]            pay_buf [MAX_LEN];

    logic timed;
    logic len_bad;
    logic chk_good;

    assign timed    = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_PAYLOAD) || (state == S_CHECK);
    assign len_bad  = (bus.data_in == 8'd0) || ({24'd0, bus.data_in} > 32'(MAX_LEN));
    assign chk_good = (bus.data_in == chk);

    assign busy_out  = (state != S_HUNT);
    assign state_dbg = state;

    // Outputs are forced to zero outside EMIT so the unreset buffer never leaks out.
    assign bus.wr_valid = (state == S_EMIT);
    assign bus.wr_addr  = bus.wr_valid ? (base_addr + ADDR_WIDTH'(idx)) : '0;
    assign bus.wr_data  = bus.wr_valid ? pay_buf[idx] : 8'd0;

    always_ff @(posedge clk_in) begin
        if (state == S_PAYLOAD && bus.valid_in) begin
            pay_buf[idx] <= bus.data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= S_HUNT;
            base_addr    <= '0;
            last_idx     <= '0;
            idx          <= '0;
            chk          <= 8'd0;
            tmo_cnt      <= '0;
            frame_ok     <= 1'b0;
            err_checksum <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
            drop_count   <= 8'd0;
        end else begin
            frame_ok     <= 1'b0;
            err_checksum <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
            tmo_cnt      <= '0;

            // A byte in the expiry cycle wins, so the timeout only acts on idle cycles.
            if (timed && !bus.valid_in) begin
                if (tmo_cnt == TMO_LAST) begin
                    err_timeout <= 1'b1;
                    state       <= S_HUNT;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            unique case (state)
                S_HUNT: begin
                    if (bus.valid_in && bus.data_in == SYNC_BYTE) begin
                        chk   <= 8'd0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.valid_in) begin
                        base_addr <= ADDR_WIDTH'(bus.data_in);
                        chk       <= chk ^ bus.data_in;
                        state     <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (bus.valid_in) begin
                        if (len_bad) begin
                            err_len <= 1'b1;
                            state   <= S_HUNT;
                        end else begin
                            last_idx <= IW'(bus.data_in - 8'd1);
                            idx      <= '0;
                            chk      <= chk ^ bus.data_in;
                            state    <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (bus.valid_in) begin
                        chk <= chk ^ bus.data_in;
                        if (idx == last_idx) begin
                            state <= S_CHECK;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (bus.valid_in) begin
                        if (chk_good) begin
                            frame_ok <= 1'b1;
                            idx      <= '0;
                            state    <= S_EMIT;
                        end else begin
                            err_checksum <= 1'b1;
                            state        <= S_HUNT;
                        end
                    end
                end
                S_EMIT: begin
                    // The UART cannot be stalled: anything arriving now is lost.
                    if (bus.valid_in && drop_count != 8'hFF) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    if (bus.wr_ready) begin
                        if (idx == last_idx) begin
                            idx   <= '0;
                            state <= S_HUNT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= S_HUNT;
            endcase
        end
    end

`ifdef UART_CMD_FRAMER_ACK_EN
    logic ack_ok_set;
    logic ack_err_set;

    assign ack_ok_set  = bus.valid_in && (state == S_CHECK) && chk_good;
    assign ack_err_set = bus.valid_in && (((state == S_CHECK) && !chk_good) ||
                                          ((state == S_LEN) && len_bad));

    // A fresh ack replaces one the host has not taken yet.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ack_valid <= 1'b0;
            ack_data  <= 8'd0;
        end else if (ack_ok_set) begin
            ack_valid <= 1'b1;
            ack_data  <= 8'h06;
        end else if (ack_err_set) begin
            ack_valid <= 1'b1;
            ack_data  <= 8'h15;
        end else if (ack_ready) begin
            ack_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Randomized bench for uart_cmd_framer: frame-level reference model, write scoreboard,
// pulse counters, directed corner cases (wrap, stall/drop, timeout edge, async reset).
module tb_uart_cmd_framer;

  localparam int MAX_LEN = 16;
  localparam int AW      = 8;
  localparam int TMO     = 40;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  uart_cmd_framer_if #(.ADDR_WIDTH(AW)) bus ();

  logic       frame_ok, err_checksum, err_len, err_timeout, busy_out;
  logic [7:0] drop_count;
  logic [2:0] state_dbg;
`ifdef UART_CMD_FRAMER_ACK_EN
  logic       ack_valid;
  logic [7:0] ack_data;
  logic       ack_ready;
  initial ack_ready = 1'b1;
`endif

  uart_cmd_framer #(
    .MAX_LEN(MAX_LEN), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(bus),
    .frame_ok(frame_ok), .err_checksum(err_checksum), .err_len(err_len),
    .err_timeout(err_timeout), .drop_count(drop_count), .busy_out(busy_out),
    .state_dbg(state_dbg)
`ifdef UART_CMD_FRAMER_ACK_EN
    , .ack_valid(ack_valid), .ack_data(ack_data), .ack_ready(ack_ready)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [15:0] exp_q[$];
  logic [7:0]  fq[$];
  int cnt_ok = 0, cnt_ck = 0, cnt_ln = 0, cnt_to = 0;
  int e_ok = 0, e_ck = 0, e_ln = 0, e_to = 0, e_drop = 0;
  int rdy_mode = 0;

  // ---------------- clock/reset helpers and drivers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.valid_in = 1'b1;
    bus.data_in  = b;
    tick();
    bus.valid_in = 1'b0;
  endtask

  initial begin
    bus.wr_ready = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      case (rdy_mode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = 1'($urandom_range(0, 1));
        default: bus.wr_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (bus.wr_valid && bus.wr_ready) begin
        check("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("wr_addr_data", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
      end else if (bus.wr_valid && exp_q.size() != 0) begin
        check("wr_hold", {bus.wr_addr, bus.wr_data}, exp_q[0]);
      end
      if (int'(frame_ok) + int'(err_checksum) + int'(err_len) + int'(err_timeout) > 1)
        check("pulse_onehot", int'(frame_ok) + int'(err_checksum) + int'(err_len) + int'(err_timeout), 1);
      cnt_ok += int'(frame_ok);
      cnt_ck += int'(err_checksum);
      cnt_ln += int'(err_len);
      cnt_to += int'(err_timeout);
    end
  end

  // ---------------- reference model ----------------
  // Parses one frame held in fq (starting at SYNC) and predicts its outcome.
  task automatic predict();
    int ln;
    logic [7:0] x, a;
    a  = fq[1];
    ln = int'(fq[2]);
    if (ln == 0 || ln > MAX_LEN) begin
      e_ln++;
      return;
    end
    x = a ^ fq[2];
    for (int i = 0; i < ln; i++) x ^= fq[3 + i];
    if (x == fq[3 + ln]) begin
      e_ok++;
      for (int i = 0; i < ln; i++) exp_q.push_back({8'(a + 8'(i)), fq[3 + i]});
    end else begin
      e_ck++;
    end
  endtask

  task automatic build(input logic [7:0] addr, input int len, input logic [7:0] corrupt);
    logic [7:0] x, b;
    fq.delete();
    fq.push_back(8'hA5);
    fq.push_back(addr);
    fq.push_back(8'(len));
    if (len == 0 || len > MAX_LEN) return;
    x = addr ^ 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      fq.push_back(b);
      x ^= b;
    end
    fq.push_back(x ^ corrupt);
  endtask

  task automatic send_frame(input int max_gap);
    foreach (fq[i]) begin
      idle($urandom_range(0, max_gap));
      send_byte(fq[i]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 2000) begin
      tick();
      n++;
    end
    check("busy_released", 32'(busy_out), 0);
    idle(2);
  endtask

  task automatic check_counts();
    check("n_frame_ok", cnt_ok, e_ok);
    check("n_err_checksum", cnt_ck, e_ck);
    check("n_err_len", cnt_ln, e_ln);
    check("n_err_timeout", cnt_to, e_to);
    check("writes_pending", exp_q.size(), 0);
    check("drop_count", drop_count, e_drop);
  endtask

  task automatic run(input int max_gap);
    predict();
    send_frame(max_gap);
    wait_idle();
    check_counts();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [7:0] b;
    int len;
    logic [7:0] corrupt;

    bus.valid_in = 1'b0;
    bus.data_in  = 8'd0;
    idle(3);
    check("rst_wr_valid", 32'(bus.wr_valid), 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_pulses", {frame_ok, err_checksum, err_len, err_timeout}, 0);
    check("rst_drop", drop_count, 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_state", state_dbg, 0);
    rst_in = 1'b1;
    idle(2);

    // basic frame, bad checksum, bad lengths
    rdy_mode = 0;
    fq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    run(2);
    fq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
    run(2);
    fq = '{8'hA5, 8'h30, 8'h00};
    run(1);
    fq = '{8'hA5, 8'h30, 8'h11};
    run(1);

    // stalled sink with bytes arriving in EMIT, address wraps
    rdy_mode = 2;
    fq = '{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC};
    predict();
    send_frame(0);
    idle(3);
    send_byte(8'h3C);
    idle(5);
    send_byte(8'hA5);
    e_drop += 2;
    idle(9);
    check("stall_addr", bus.wr_addr, 8'hFF);
    check("stall_data", bus.wr_data, 8'hAA);
    rdy_mode = 0;
    wait_idle();
    check_counts();

    // timeout fires after TMO idle cycles
    fq = '{8'hA5, 8'h10};
    send_frame(0);
    idle(TMO);
    e_to++;
    idle(2);
    check("tmo_busy", 32'(busy_out), 0);
    check("tmo_state", state_dbg, 0);
    check_counts();

    // byte landing in the last allowed cycle is consumed
    fq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    predict();
    send_byte(8'hA5);
    send_byte(8'h10);
    idle(TMO - 1);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h21);
    wait_idle();
    check_counts();

    // randomized frames with HUNT garbage and random sink back-pressure
    repeat (40) begin
      rdy_mode = $urandom_range(0, 1);
      n = $urandom_range(0, 3);
      repeat (n) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b);
      end
      n = $urandom_range(0, 99);
      if (n < 5)       len = 0;
      else if (n < 10) len = $urandom_range(MAX_LEN + 1, 255);
      else             len = $urandom_range(1, MAX_LEN);
      corrupt = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      build(8'($urandom_range(0, 255)), len, corrupt);
      run(3);
    end

    // drop counter saturation
    rdy_mode = 2;
    build(8'h40, 1, 8'd0);
    predict();
    send_frame(0);
    repeat (260) send_byte(8'($urandom_range(0, 255)));
    e_drop = (e_drop + 260 > 255) ? 255 : e_drop + 260;
    check("drop_saturate", drop_count, e_drop);
    rdy_mode = 0;
    wait_idle();
    check_counts();

    // asynchronous reset in the middle of a payload
    fq = '{8'hA5, 8'h20, 8'h05, 8'h01, 8'h02};
    send_frame(0);
    #2;
    rst_in = 1'b0;
    #1;
    check("arst_busy", 32'(busy_out), 0);
    check("arst_state", state_dbg, 0);
    check("arst_drop", drop_count, 0);
    check("arst_wr_valid", 32'(bus.wr_valid), 0);
    e_drop = 0;
    idle(2);
    rst_in = 1'b1;
    idle(2);
    build(8'hF8, MAX_LEN, 8'd0);
    run(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
